mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Issues loads and stores to data memory over a valid/ready request channel and a valid response channel.
- Aligns store data and generates byte enables; extracts and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding and drives the MEM/WB-side result, rd and reg_write registers.

Parameters:
TIMEOUT_CYCLES, 255, maximum WAIT_RSP cycles before the load is abandoned with a bus error; legal range 1..65535.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ex_mem_alu_result  in  32  ALU result; byte address for memory ops
ex_mem_mem_write_data  in  32  store data, unaligned in bits [7:0]/[15:0]/[31:0]
ex_mem_rd  in  5  destination register
ex_mem_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_mem_mem_write  in  1  store
ex_mem_mem_read  in  1  load
ex_mem_reg_write  in  1  register write enable
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  request accepted
dmem_req_we  out  1  1 = write
dmem_req_addr  out  32  word address, bits [1:0] = 0
dmem_req_wdata  out  32  lane-replicated store data
dmem_req_be  out  4  byte enables
dmem_rsp_valid  in  1  load response valid
dmem_rsp_rdata  in  32  load response word
mem_stall  out  1  freeze EX/MEM and earlier stages
mem_bus_err  out  1  one-cycle pulse on load timeout
mem_wb_result  out  32  result to WB
mem_wb_rd  out  5  rd to WB
mem_wb_reg_write  out  1  WB write enable

Behaviour:
- Reset: FSM = IDLE. All outputs are 0, including dmem_req_valid, mem_stall and mem_wb_*. Reset is asynchronous and may occur in any state; the outstanding request is dropped and late responses are ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, non-memory op:
  - On each edge, mem_wb_result <= alu_result, mem_wb_rd <= rd, mem_wb_reg_write <= reg_write.
  - 1-cycle latency; mem_stall = 0.
- IDLE, memory op (read or write high):
  - mem_stall = 1 combinationally in the same cycle.
  - The address, data, funct3 and rd are captured at the edge; FSM -> REQ; mem_wb_reg_write <= 0 (bubble).
- Read and write both high: treated as a store.
- REQ:
  - dmem_req_valid = 1; addr, we, be and wdata are driven from the captured values and held stable until dmem_req_ready.
  - On the handshake edge: a store -> DONE (posted, no response expected); a load -> WAIT_RSP with the timeout counter cleared.
- WAIT_RSP:
  - On dmem_rsp_valid: the extracted, extended data is written to mem_wb_result and mem_wb_rd; mem_wb_reg_write <= captured reg_write; FSM -> DONE.
  - If the counter reaches TIMEOUT_CYCLES: mem_bus_err pulses for 1 cycle, mem_wb_reg_write <= 0, FSM -> DONE.
- Responses in IDLE or REQ are ignored.
- DONE:
  - mem_stall = 0; the EX/MEM inputs still show the completed op and are ignored (no reissue).
  - At the next edge: mem_wb_reg_write <= 0, FSM -> IDLE. Every instruction retires exactly once.
- Store lanes, with a = addr[1:0]:
  - SB: wdata = {4{d[7:0]}}, be = 0001 << a.
  - SH: wdata = {2{d[15:0]}}, be = 0011 << {a[1],0}.
  - SW: wdata = d, be = 1111.
- Loads: the byte or half selected by the address bits is extracted. B and H sign-extend from bit 7/15; BU and HU zero-extend; W passes the word through. Other funct3 values behave as W.
- mem_stall is 1 in IDLE with a memory op, and in REQ and WAIT_RSP; 0 otherwise.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - A misaligned access is a half with a[0] = 1 or a word with a != 0.
  - It issues no dmem request: IDLE -> DONE directly with stall held through the capture cycle.
  - Output mem_misalign (1 bit) pulses for 1 cycle and mem_wb_reg_write is forced to 0.
- Undefined: no mem_misalign port. Half accesses ignore a[0]; word accesses ignore a[1:0].

Test Plan:
1. Reset released, then ADD with alu_result=0x1234, rd=5, reg_write=1 -> next cycle mem_wb_result=0x1234, rd=5, reg_write=1, mem_stall never 1.
2. SB, addr=0x103, data=0xAB, ready held low 3 cycles -> valid held steady, addr=0x100, be=1000, wdata=0xABABABAB, stall=1 throughout; after DONE, mem_wb_reg_write pulses 0 only.
3. LB, addr=0x101, rsp_rdata=0x00008000 after 2 cycles -> mem_wb_result=0x00000080 sign-extended to 0xFFFFFF80; LBU gives 0x00000080.
4. LW with no response, TIMEOUT_CYCLES=4 -> mem_bus_err pulses exactly once after 4 WAIT cycles, reg_write=0, stall releases.
5. reset_n asserted in WAIT_RSP, then rsp_valid=1 -> all outputs 0, response ignored, FSM IDLE.
6. With MEM_MISALIGN_TRAP_EN: LH, addr=0x201 -> mem_misalign=1 for 1 cycle, dmem_req_valid never 1, mem_wb_reg_write=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage and data memory: a valid/ready
// request channel and a valid-only response channel.
interface mem_access_unit_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Issues one data-memory access per memory
// instruction, stalls earlier stages while it is outstanding, aligns store
// data / byte enables, extends load data and drives the MEM/WB registers.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// are not issued and raise a one-cycle mem_misalign pulse instead.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_mem_write_data,
  input  logic [4:0]  ex_mem_rd,
  input  logic [2:0]  ex_mem_funct3,
  input  logic        ex_mem_mem_write,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_reg_write,
  mem_access_unit_if.master dmem,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        mem_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        mem_op;
  logic        misalign;
  logic        tmo_hit;
  logic [15:0] tmo_cnt;

  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [2:0]  cap_funct3;
  logic [4:0]  cap_rd;
  logic        cap_we;
  logic        cap_reg_write;

  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign mem_op  = ex_mem_mem_read | ex_mem_mem_write;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  // Flag half accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    misalign = 1'b0;
    case (ex_mem_funct3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ex_mem_alu_result[0];
      default: misalign = |ex_mem_alu_result[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and stall; stall is gated by reset so it reads 0 while held in reset.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          state_d   = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem.dmem_req_ready) state_d = cap_we ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        mem_stall = 1'b1;
        if (dmem.dmem_rsp_valid || tmo_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_stall = mem_stall & reset_n;
  end

  // Store lane replication and byte enables from the captured access.
  always_comb begin
    store_be    = '0;
    store_wdata = '0;
    case (cap_funct3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << cap_addr[1:0];
        store_wdata = {4{cap_data[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << {cap_addr[1], 1'b0};
        store_wdata = {2{cap_data[15:0]}};
      end
      default: begin
        store_be    = '1;
        store_wdata = cap_data;
      end
    endcase
  end

  // Request channel is only driven while a request is pending.
  always_comb begin
    dmem.dmem_req_valid = 1'b0;
    dmem.dmem_req_we    = 1'b0;
    dmem.dmem_req_addr  = '0;
    dmem.dmem_req_wdata = '0;
    dmem.dmem_req_be    = '0;
    if (state_q == REQ) begin
      dmem.dmem_req_valid = 1'b1;
      dmem.dmem_req_we    = cap_we;
      dmem.dmem_req_addr  = {cap_addr[31:2], 2'b00};
      dmem.dmem_req_wdata = store_wdata;
      dmem.dmem_req_be    = store_be;
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_byte = '0;
    case (cap_addr[1:0])
      2'd0: ld_byte = dmem.dmem_rsp_rdata[7:0];
      2'd1: ld_byte = dmem.dmem_rsp_rdata[15:8];
      2'd2: ld_byte = dmem.dmem_rsp_rdata[23:16];
      2'd3: ld_byte = dmem.dmem_rsp_rdata[31:24];
      default: ld_byte = '0;
    endcase
    ld_half = cap_addr[1] ? dmem.dmem_rsp_rdata[31:16] : dmem.dmem_rsp_rdata[15:0];
    case (cap_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem.dmem_rsp_rdata;
    endcase
  end

  // Access capture, timeout counter and MEM/WB result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_addr         <= '0;
      cap_data         <= '0;
      cap_funct3       <= '0;
      cap_rd           <= '0;
      cap_we           <= 1'b0;
      cap_reg_write    <= 1'b0;
      tmo_cnt          <= '0;
      mem_bus_err      <= 1'b0;
      mem_wb_result    <= '0;
      mem_wb_rd        <= '0;
      mem_wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign     <= 1'b0;
`endif
    end else begin
      mem_bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            cap_addr         <= ex_mem_alu_result;
            cap_data         <= ex_mem_mem_write_data;
            cap_funct3       <= ex_mem_funct3;
            cap_rd           <= ex_mem_rd;
            cap_we           <= ex_mem_mem_write;
            cap_reg_write    <= ex_mem_reg_write;
            mem_wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_misalign     <= misalign;
`endif
          end else begin
            mem_wb_result    <= ex_mem_alu_result;
            mem_wb_rd        <= ex_mem_rd;
            mem_wb_reg_write <= ex_mem_reg_write;
          end
        end
        REQ: begin
          if (dmem.dmem_req_ready && !cap_we) tmo_cnt <= '0;
        end
        WAIT_RSP: begin
          if (dmem.dmem_rsp_valid) begin
            mem_wb_result    <= ld_data;
            mem_wb_rd        <= cap_rd;
            mem_wb_reg_write <= cap_reg_write;
          end else if (tmo_hit) begin
            mem_bus_err      <= 1'b1;
            mem_wb_reg_write <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE:    mem_wb_reg_write <= 1'b0;
        default: mem_wb_reg_write <= 1'b0;
      endcase
    end
  end

endmodule
